alu_muldiv: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational AND/OR/ADD/SUB/SLT path, with every op code defined.
- Adds an iterative multiply/divide engine with HI/LO result registers, a start/busy/done handshake and divide-by-zero reporting, for MULT/MULTU/DIV/DIVU support.
- Sits in the EX stage. The control unit stalls the PC while md_busy is high.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_muldiv_if.sv | 19 +
 rtl/muldiv_seq.sv | 87 ++++++++
 rtl/alu_muldiv.sv | 36 +++
 tb/tb_alu_muldiv.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes and engine state encoding for alu_muldiv
package alu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} md_state_t;
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand/result bus of alu_muldiv; ALU_HILO_WRITE_EN adds hi_we/lo_we
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] a, b, result, hi, lo;
    logic [2:0] alu_op;
    logic [1:0] md_op;
    logic zero, md_start, md_busy, md_done, div_by_zero;
`ifdef ALU_HILO_WRITE_EN
    logic hi_we, lo_we;
    modport master(output a, b, alu_op, md_start, md_op, hi_we, lo_we,
                   input result, zero, md_busy, md_done, hi, lo, div_by_zero);
    modport slave(input a, b, alu_op, md_start, md_op, hi_we, lo_we,
                  output result, zero, md_busy, md_done, hi, lo, div_by_zero);
`else
    modport master(output a, b, alu_op, md_start, md_op,
                   input result, zero, md_busy, md_done, hi, lo, div_by_zero);
    modport slave(input a, b, alu_op, md_start, md_op,
                  output result, zero, md_busy, md_done, hi, lo, div_by_zero);
`endif
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiply / restoring divide with HI/LO (ALU_HILO_WRITE_EN adds MTHI/MTLO)
module muldiv_seq import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
`ifdef ALU_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
`endif
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    md_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] p, prod_fix;
    logic [WIDTH-1:0] m, a_q, ma, mb, diff, q_fix, r_fix;
    logic [WIDTH:0] add_s, trial;
    logic is_div, neg_q, neg_r, dbz_q, sgn, sa, sb, ge;
    assign sgn = md_op == MD_MULT || md_op == MD_DIV;
    assign sa = sgn & a[WIDTH-1];
    assign sb = sgn & b[WIDTH-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;
    assign add_s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    assign trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign ge = trial >= {1'b0, m};
    assign diff = trial[WIDTH-1:0] - m;
    assign prod_fix = neg_q ? -p : p;
    assign q_fix = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign r_fix = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    assign md_busy = state != ST_IDLE;
    // engine state register
    always_ff @(posedge clk)
        state <= reset ? ST_IDLE : state_nx;
    // IDLE -> RUN on start, RUN for WIDTH steps, one FIX cycle for sign correction
    always_comb begin
        state_nx = state == ST_IDLE ? (md_start ? ST_RUN : ST_IDLE)
                 : state == ST_RUN  ? (cnt == '0 ? ST_FIX : ST_RUN)
                 : ST_IDLE;
    end
    // operand capture, one iteration per RUN cycle, hi/lo writeback in FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            md_done <= 1'b0;
            div_by_zero <= 1'b0;
            cnt <= '0;
        end else begin
            md_done <= state == ST_FIX;
            if (state == ST_IDLE) begin
`ifdef ALU_HILO_WRITE_EN
                if (hi_we) hi <= a;
                if (lo_we) lo <= a;
`endif
                if (md_start) begin
                    is_div <= md_op[1];
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    a_q <= a;
                    dbz_q <= md_op[1] && b == '0;
                    div_by_zero <= 1'b0;
                    cnt <= CW'(WIDTH - 1);
                    m <= md_op[1] ? mb : ma;
                    p <= {{WIDTH{1'b0}}, md_op[1] ? ma : mb};
                end
            end else if (state == ST_RUN) begin
                cnt <= cnt - 1'b1;
                p <= is_div ? {ge ? diff : trial[WIDTH-1:0], p[WIDTH-2:0], ge}
                            : {add_s, p[WIDTH-1:1]};
            end else begin
                hi <= !is_div ? prod_fix[2*WIDTH-1:WIDTH] : dbz_q ? a_q : r_fix;
                lo <= !is_div ? prod_fix[WIDTH-1:0] : dbz_q ? '1 : q_fix;
                div_by_zero <= dbz_q;
            end
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational EX-stage ALU plus iterative mul/div engine (optional ALU_HILO_WRITE_EN)
module alu_muldiv import alu_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b1
) (
    input logic        clk,
    input logic        reset,
    alu_muldiv_if.slave bus
);
    logic lt;
    assign lt = SLT_SIGNED ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
    assign bus.result = bus.alu_op == ALU_AND ? bus.a & bus.b
                      : bus.alu_op == ALU_OR  ? bus.a | bus.b
                      : bus.alu_op == ALU_ADD ? bus.a + bus.b
                      : bus.alu_op == ALU_SUB ? bus.a - bus.b
                      : bus.alu_op == ALU_SLT ? {{(WIDTH-1){1'b0}}, lt}
                      : '0;
    assign bus.zero = bus.result == '0;
    muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clk(clk),
        .reset(reset),
        .a(bus.a),
        .b(bus.b),
        .md_start(bus.md_start),
        .md_op(bus.md_op),
`ifdef ALU_HILO_WRITE_EN
        .hi_we(bus.hi_we),
        .lo_we(bus.lo_we),
`endif
        .md_busy(bus.md_busy),
        .md_done(bus.md_done),
        .hi(bus.hi),
        .lo(bus.lo),
        .div_by_zero(bus.div_by_zero)
    );
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors plus a cycle-level reference model checked every cycle
module tb_alu_muldiv;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    alu_muldiv_if #(.WIDTH(32)) bus();
    alu_muldiv #(.WIDTH(32), .SLT_SIGNED(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    int pass_cnt = 0;
    int total = 0;
    bit chk_en = 1'b0;
    int m_left = 0;
    logic m_done = 1'b0, m_dbz = 1'b0, pend_dbz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] pend = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'b000: return x & y;
            3'b001: return x | y;
            3'b010: return x + y;
            3'b110: return x - y;
            3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] md_model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res, ql, rl;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op[1] && y == 0) return {x, 32'hFFFF_FFFF};
        case (op)
            2'b00: res = sx * sy;
            2'b01: res = {32'd0, x} * {32'd0, y};
            2'b10: begin
                q = sx / sy;
                r = sx % sy;
                ql = q;
                rl = r;
                res = {rl[31:0], ql[31:0]};
            end
            default: res = {x % y, x / y};
        endcase
        return res;
    endfunction

    // reference model: busy for 33 cycles after an accepted start, result lands with done
    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi <= '0;
            m_lo <= '0;
            m_dbz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= pend[63:32];
                    m_lo <= pend[31:0];
                    m_dbz <= pend_dbz;
                    m_done <= 1'b1;
                end
            end else begin
`ifdef ALU_HILO_WRITE_EN
                if (bus.hi_we) m_hi <= bus.a;
                if (bus.lo_we) m_lo <= bus.a;
`endif
                if (bus.md_start) begin
                    pend <= md_model(bus.md_op, bus.a, bus.b);
                    pend_dbz <= bus.md_op[1] && bus.b == 0;
                    m_dbz <= 1'b0;
                    m_left <= 33;
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("result", bus.result, alu_model(bus.alu_op, bus.a, bus.b));
            check("zero", bus.zero, alu_model(bus.alu_op, bus.a, bus.b) == 0);
            check("md_busy", bus.md_busy, m_left > 0);
            check("md_done", bus.md_done, m_done);
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
            check("div_by_zero", bus.div_by_zero, m_dbz);
        end
    end

    task automatic alu_vec(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] er, input logic ez);
        bus.alu_op = op;
        bus.a = x;
        bus.b = y;
        #1;
        check("alu_result_lit", bus.result, er);
        check("alu_zero_lit", bus.zero, ez);
        @(negedge clk);
    endtask

    task automatic wait_done(input logic [31:0] eh, input logic [31:0] el, input logic ed, input int ecyc);
        int cyc = 0;
        int n = 0;
        while (!bus.md_done && n < 100) begin
            if (bus.md_busy) cyc++;
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.md_done, 1'b1);
        check("busy_cycles", cyc, ecyc);
        check("hi_lit", bus.hi, eh);
        check("lo_lit", bus.lo, el);
        check("dbz_lit", bus.div_by_zero, ed);
    endtask

    task automatic run_md(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
        bus.md_start = 1'b1;
        bus.md_op = op;
        bus.a = x;
        bus.b = y;
        @(negedge clk);
        check("dbz_clear_at_start", bus.div_by_zero, 1'b0);
        bus.md_start = 1'b0;
        bus.md_op = ~op;
        bus.a = ~x;
        bus.b = $urandom;
        wait_done(eh, el, ed, 33);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.alu_op = 3'b000;
        bus.md_start = 1'b0;
        bus.md_op = 2'b00;
`ifdef ALU_HILO_WRITE_EN
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", bus.md_busy, 1'b0);
        check("rst_done", bus.md_done, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        reset = 1'b0;
        alu_vec(3'b010, 32'd7, 32'd5, 32'd12, 1'b0);
        alu_vec(3'b110, 32'd5, 32'd5, 32'd0, 1'b1);
        alu_vec(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        alu_vec(3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        alu_vec(3'b011, 32'h1234, 32'h5678, 32'd0, 1'b1);
        alu_vec(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        alu_vec(3'b101, 32'h8000_0000, 32'd1, 32'd0, 1'b1);
        alu_vec(3'b000, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0);
        alu_vec(3'b001, 32'hF000, 32'h000F, 32'hF00F, 1'b0);
        alu_vec(3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        alu_vec(3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run_md(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_md(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_md(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_md(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_md(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_md(2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        run_md(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        run_md(2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        bus.md_start = 1'b1;
        bus.md_op = 2'b11;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(negedge clk);
        bus.md_start = 1'b0;
        repeat (4) @(negedge clk);
        bus.md_start = 1'b1;
        bus.md_op = 2'b00;
        bus.a = 32'd2;
        bus.b = 32'd3;
        @(negedge clk);
        bus.md_start = 1'b0;
        wait_done(32'd2, 32'd14, 1'b0, 28);
        @(negedge clk);
        bus.md_start = 1'b1;
        bus.md_op = 2'b01;
        bus.a = 32'hFFFF;
        bus.b = 32'hFFFF;
        @(negedge clk);
        bus.md_start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus.md_busy, 1'b0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.md_done) dones++;
        end
        check("abort_no_done", dones, 0);
`ifdef ALU_HILO_WRITE_EN
        bus.hi_we = 1'b1;
        bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_lit", bus.hi, 32'hDEAD_BEEF);
        bus.md_start = 1'b1;
        bus.md_op = 2'b01;
        bus.a = 32'd6;
        bus.b = 32'd7;
        @(negedge clk);
        bus.md_start = 1'b0;
        bus.lo_we = 1'b1;
        bus.a = 32'h5555_AAAA;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_busy_lit", bus.lo, 32'd0);
        wait_done(32'd0, 32'd42, 1'b0, 32);
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
